icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache; successor to the fixed direct-mapped icache.
- Sits between the datapath fetch port and the memory controller instruction channel, inside the caches block.
- Generalised in sets, ways and words per block, with multi-word line fill, per-set replacement and a one-cycle invalidate.

Parameters:
SETS, 8, number of sets; power of two, >=2
WAYS, 2, associativity; power of two, 1..8
WORDS, 2, 32-bit words per block; power of two, 1..8

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
imemREN  in  1  datapath fetch request
imemaddr  in  32  fetch byte address; bits [1:0] ignored
ihit  out  1  fetch satisfied this cycle
imemload  out  32  instruction word, valid while ihit
invalidate  in  1  clear all valid bits
iREN  out  1  memory read request
iaddr  out  32  memory word address, bits [1:0]=0
iwait  in  1  memory busy; iload valid when low with iREN high
iload  in  32  memory read data

Behaviour:
- Address split: [1:0] byte, next log2(WORDS) bits block offset, next log2(SETS) bits index, remainder tag. A width-0 field is absent.
- Storage: per way/set: valid, tag, WORDS data words. Per set: round-robin victim pointer, log2(WAYS) bits, wraps WAYS-1 -> 0.
- States: IDLE, FILL.
- IDLE:
  - ihit = imemREN & any way valid with matching tag. Combinational, same cycle.
  - imemload = the matching way's word at the block offset; 32'h0 when ihit is low.
  - Miss (imemREN & no match): latch tag, index and victim way; fill counter k=0; next state FILL.
- Victim selection: lowest-index invalid way in the set. If all ways are valid, the way named by the set's pointer.
- FILL:
  - iREN=1; iaddr = {latched tag, index, k, 2'b00}; ihit=0; imemload=0.
  - Each cycle with iwait=0: store iload into word k of a staging line, k++.
  - After word WORDS-1 is accepted: write the line, set valid, write the tag. Advance the pointer only if the victim was already valid. Return to IDLE.
  - The original request hits on the next cycle.
  - Zero-wait miss penalty: 1+WORDS cycles from request to ihit.
- Outside FILL, iREN=0 and iaddr=0.
- Request change mid-fill (imemREN drops or imemaddr changes): the fill completes and installs the originally latched line. The new address is compared afterwards in IDLE.
- invalidate:
  - Highest priority after RST. Next edge clears every valid bit, aborts any fill with no install, and goes to IDLE.
  - While invalidate is high, ihit=0.
  - Pointers are not cleared.
- RST: state IDLE, all valid=0, pointers=0, k=0. Outputs the cycle after: ihit=0, imemload=0, iREN=0, iaddr=0.
  - Reset mid-fill discards partial data.
- Data and tag arrays need no reset.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE -> FILL transition.
  - Both saturate at 32'hFFFFFFFF.
  - Both are cleared by RST and by invalidate.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss (defaults, iwait=0): imemREN=1, imemaddr=0x100.
  - iREN=1 with iaddr=0x100 then 0x104 on cycles 1-2.
  - ihit=1 on cycle 3 with imemload = word returned at 0x100.
  - Then imemaddr=0x104 hits immediately.
- Associativity: fill 0x100 then 0x200 (same set 0, different tags).
  - Both then hit with no iREN.
  - A third tag 0x300 evicts way 0 (0x100): 0x100 misses, 0x200 hits.
- Wait states: iwait=1 for 3 cycles before each word.
  - iaddr holds 0x100 until its word is accepted.
  - ihit first asserts 9 cycles after the request.
- Mid-fill change: miss on 0x100; after word 0, switch imemaddr to 0x400.
  - Fill of 0x100/0x104 completes.
  - 0x400 then misses and fills.
  - 0x100 later hits.
- Invalidate mid-fill: pulse invalidate during FILL.
  - iREN=0 the next cycle.
  - A previously cached 0x200 now misses.
  - The aborted line is not installed.
- ICACHE_STATS_EN: 2 misses + 5 hits -> miss_count=2, hit_count=5. After invalidate both read 0.

Source files
------------

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word line fill and per-set round-robin replacement.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache_assoc #(
   parameter int SETS  = 8,
   parameter int WAYS  = 2,
   parameter int WORDS = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        invalidate,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int OFF_B = (OFF_W > 0) ? OFF_W : 1;
   localparam int IDX_B = (IDX_W > 0) ? IDX_W : 1;
   localparam int WAY_B = (WAY_W > 0) ? WAY_W : 1;
   localparam int TAG_W = 30 - OFF_W - IDX_W;

   typedef enum logic {IDLE, FILL} state_t;

   function automatic logic [WAY_B-1:0] next_ptr(input logic [WAY_B-1:0] p);
      if (WAYS == 1) return '0;
      return (p == WAY_B'(WAYS - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   state_t            state;
   logic [SETS-1:0]   valid    [WAYS];
   logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
   logic [31:0]       data_mem [WAYS][SETS][WORDS];
   logic [WAY_B-1:0]  ptr      [SETS];
   logic [31:0]       stage    [WORDS];

   logic [TAG_W-1:0]  l_tag;
   logic [IDX_B-1:0]  l_idx;
   logic [WAY_B-1:0]  l_way;
   logic              l_was_valid;
   logic [OFF_B-1:0]  k;

   logic [29:0]       waddr;
   logic [OFF_B-1:0]  req_off;
   logic [IDX_B-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic              hit_any;
   logic [WAY_B-1:0]  hit_way;
   logic [WAY_B-1:0]  vic_way;
   logic              vic_valid;
   logic              miss;
   logic              last;
   logic              accept;
   logic [29:0]       fill_waddr;
   logic              unused_bits;

   assign unused_bits = &{1'b0, imemaddr[1:0]};
   assign waddr   = imemaddr[31:2];
   assign req_off = OFF_B'(waddr & 30'(WORDS - 1));
   assign req_idx = IDX_B'((waddr >> OFF_W) & 30'(SETS - 1));
   assign req_tag = TAG_W'(waddr >> (OFF_W + IDX_W));

   // Lookup and victim choice: first matching way; lowest invalid way, else the set pointer
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit_any && valid[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
            hit_any = 1'b1;
            hit_way = WAY_B'(w);
         end
      end
      vic_way   = ptr[req_idx];
      vic_valid = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w][req_idx]) begin
            vic_way   = WAY_B'(w);
            vic_valid = 1'b0;
         end
      end
   end

   assign miss       = (state == IDLE) && imemREN && !hit_any;
   assign last       = (k == OFF_B'(WORDS - 1));
   assign accept     = (state == FILL) && !iwait;
   assign fill_waddr = (30'(l_tag) << (OFF_W + IDX_W)) | (30'(l_idx) << OFF_W) | 30'(k);

   assign ihit     = (state == IDLE) && imemREN && hit_any && !invalidate;
   assign imemload = ihit ? data_mem[hit_way][req_idx][req_off] : 32'h0;
   assign iREN     = (state == FILL);
   assign iaddr    = iREN ? {fill_waddr, 2'b00} : 32'h0;

   // Control: state, fill counter, valid bits, replacement pointers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         k     <= '0;
         for (int w = 0; w < WAYS; w++) valid[w] <= '0;
         for (int s = 0; s < SETS; s++) ptr[s] <= '0;
      end else if (invalidate) begin
         state <= IDLE;
         k     <= '0;
         for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss) begin
                  l_tag       <= req_tag;
                  l_idx       <= req_idx;
                  l_way       <= vic_way;
                  l_was_valid <= vic_valid;
                  k           <= '0;
                  state       <= FILL;
               end
            end
            FILL: begin
               if (!iwait) begin
                  if (last) begin
                     valid[l_way][l_idx] <= 1'b1;
                     if (l_was_valid) ptr[l_idx] <= next_ptr(ptr[l_idx]);
                     k     <= '0;
                     state <= IDLE;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data: staging line and array install, written only on an uninterrupted fill
   always_ff @(posedge CLK) begin
      if (accept && !RST && !invalidate) begin
         stage[k] <= iload;
         if (last) begin
            tag_mem[l_way][l_idx] <= l_tag;
            for (int w = 0; w < WORDS; w++)
               data_mem[l_way][l_idx][w] <= (OFF_B'(w) == k) ? iload : stage[w];
         end
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST || invalidate) begin
         hit_count  <= 32'h0;
         miss_count <= 32'h0;
      end else begin
         if (ihit) hit_count  <= sat_inc(hit_count);
         if (miss) miss_count <= sat_inc(miss_count);
      end
   end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: memory responder, cache-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_icache_assoc;
   localparam int SETS  = 8;
   localparam int WAYS  = 2;
   localparam int WORDS = 2;

   logic        CLK = 1'b0;
   logic        RST, imemREN, invalidate, iwait;
   logic [31:0] imemaddr, iload;
   logic        ihit, iREN;
   logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int tests = 0;
   int fails = 0;
   int wait_cycles = 0;
   int wcnt = 0;

   icache_assoc #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .invalidate(invalidate),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory: data is a fixed function of the word address, garbage while busy
   assign iload = iwait ? 32'hDEAD_DEAD : memf(iaddr);

   initial iwait = 1'b0;
   always @(posedge CLK) begin
      #1;
      if (iREN && wait_cycles > 0) begin
         if (wcnt < wait_cycles) begin iwait = 1'b1; wcnt++; end
         else begin iwait = 1'b0; wcnt = 0; end
      end else begin
         iwait = 1'b0;
         wcnt  = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: which lines are resident, and the outstanding fill
   bit          m_valid [WAYS][SETS];
   int unsigned m_tag   [WAYS][SETS];
   int          m_ptr   [SETS];
   bit          m_fill, m_ready, m_wasvalid;
   int unsigned m_base, m_ftag;
   int          m_k, m_way, m_set;

   function automatic int set_of(input int unsigned a);
      return int'((a / (4 * WORDS)) % SETS);
   endfunction

   function automatic int unsigned tag_of(input int unsigned a);
      return a / (4 * WORDS * SETS);
   endfunction

   function automatic bit present(input int unsigned a);
      for (int w = 0; w < WAYS; w++)
         if (m_valid[w][set_of(a)] && m_tag[w][set_of(a)] == tag_of(a)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      if (RST) begin
         for (int w = 0; w < WAYS; w++) for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
         for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
         m_fill  = 1'b0;
         m_ready = 1'b1;
      end else if (!m_ready) begin
         m_fill = 1'b0;
      end else if (invalidate) begin
         for (int w = 0; w < WAYS; w++) for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
         m_fill = 1'b0;
      end else if (m_fill) begin
         if (!iwait) begin
            m_k++;
            if (m_k == WORDS) begin
               if (m_wasvalid) m_ptr[m_set] = (m_ptr[m_set] + 1) % WAYS;
               m_valid[m_way][m_set] = 1'b1;
               m_tag[m_way][m_set]   = m_ftag;
               m_fill = 1'b0;
            end
         end
      end else if (imemREN && !present(imemaddr)) begin
         m_set = set_of(imemaddr);
         m_ftag = tag_of(imemaddr);
         m_way = -1;
         for (int w = 0; w < WAYS; w++)
            if (m_way < 0 && !m_valid[w][m_set]) m_way = w;
         m_wasvalid = (m_way < 0);
         if (m_way < 0) m_way = m_ptr[m_set];
         m_base = imemaddr & ~(32'(4 * WORDS) - 32'd1);
         m_k    = 0;
         m_fill = 1'b1;
      end
   endtask

   initial begin : compare
      logic exp_hit;
      m_ready = 1'b0;
      m_fill  = 1'b0;
      forever begin
         @(negedge CLK);
         if (m_ready) begin
            exp_hit = !m_fill && imemREN && !invalidate && present(imemaddr);
            chk("model_ihit", 32'(ihit), 32'(exp_hit));
            chk("model_imemload", imemload, exp_hit ? memf(imemaddr & ~32'd3) : 32'h0);
            chk("model_iREN", 32'(iREN), 32'(m_fill));
            chk("model_iaddr", iaddr, m_fill ? m_base + 32'(4 * m_k) : 32'h0);
         end
         @(posedge CLK);
         model_step();
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic req(input logic [31:0] a);
      imemREN  = 1'b1;
      imemaddr = a;
   endtask

   // Called at a negedge; advances until ihit or the cycle budget runs out
   task automatic wait_hit(input string name, input int maxc, output int n);
      n = 0;
      while (!ihit && n < maxc) begin
         cyc();
         @(negedge CLK);
         n++;
      end
      tests++;
      if (!ihit) begin
         fails++;
         $display("FAIL %s: ihit not seen within %0d cycles", name, maxc);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int n;
      int first;
      RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; invalidate = 1'b0;
      cyc(); cyc();
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_ihit", 32'(ihit), 32'h0);
      chk("rst_imemload", imemload, 32'h0);
      chk("rst_iREN", 32'(iREN), 32'h0);
      chk("rst_iaddr", iaddr, 32'h0);

      // Cold miss on 0x100
      cyc(); req(32'h100); @(negedge CLK);
      chk("cold_c0_ihit", 32'(ihit), 32'h0);
      chk("cold_c0_iREN", 32'(iREN), 32'h0);
      cyc(); @(negedge CLK);
      chk("cold_c1_iREN", 32'(iREN), 32'h1);
      chk("cold_c1_iaddr", iaddr, 32'h100);
      cyc(); @(negedge CLK);
      chk("cold_c2_iaddr", iaddr, 32'h104);
      cyc(); @(negedge CLK);
      chk("cold_c3_ihit", 32'(ihit), 32'h1);
      chk("cold_c3_load", imemload, 32'h0100_FEFF);
      cyc(); req(32'h104); @(negedge CLK);
      chk("cold_104_ihit", 32'(ihit), 32'h1);
      chk("cold_104_load", imemload, 32'h0104_FEFB);

      // Associativity and round-robin eviction in set 0
      cyc(); req(32'h200); @(negedge CLK);
      wait_hit("fill_200", 10, n);
      chk("fill_200_latency", 32'(n), 32'd3);
      cyc(); req(32'h100); @(negedge CLK);
      chk("assoc_100_hit", 32'(ihit), 32'h1);
      chk("assoc_100_iREN", 32'(iREN), 32'h0);
      cyc(); req(32'h200); @(negedge CLK);
      chk("assoc_200_hit", 32'(ihit), 32'h1);
      cyc(); req(32'h300); @(negedge CLK);
      wait_hit("fill_300", 10, n);
      cyc(); req(32'h200); @(negedge CLK);
      chk("evict_200_hit", 32'(ihit), 32'h1);
      cyc(); req(32'h100); @(negedge CLK);
      chk("evict_100_miss", 32'(ihit), 32'h0);
      wait_hit("refill_100", 10, n);

      // Wait states: 3 busy cycles before every word
      cyc(); imemREN = 1'b0; invalidate = 1'b1;
      cyc(); invalidate = 1'b0; wait_cycles = 3; req(32'h100); @(negedge CLK);
      first = -1;
      for (int c = 1; c <= 12; c++) begin
         cyc(); @(negedge CLK);
         if (c <= 4) chk("ws_iaddr_hold", iaddr, 32'h100);
         if (ihit && first < 0) first = c;
      end
      chk("ws_latency", 32'(first), 32'd9);
      chk("ws_load", imemload, 32'h0100_FEFF);
      wait_cycles = 0;

      // Request change mid-fill
      cyc(); imemREN = 1'b0; invalidate = 1'b1;
      cyc(); invalidate = 1'b0; req(32'h100); @(negedge CLK);
      cyc(); @(negedge CLK);
      chk("mid_c1_iaddr", iaddr, 32'h100);
      cyc(); req(32'h400); @(negedge CLK);
      chk("mid_c2_iaddr", iaddr, 32'h104);
      cyc(); @(negedge CLK);
      chk("mid_400_miss", 32'(ihit), 32'h0);
      wait_hit("fill_400", 10, n);
      chk("mid_400_load", imemload, 32'h0400_FBFF);
      cyc(); req(32'h100); @(negedge CLK);
      chk("mid_100_hit", 32'(ihit), 32'h1);

      // Invalidate during a fill
      cyc(); req(32'h200); @(negedge CLK);
      wait_hit("fill_200b", 10, n);
      cyc(); req(32'h600); @(negedge CLK);
      cyc(); invalidate = 1'b1; @(negedge CLK);
      chk("inv_ihit_low", 32'(ihit), 32'h0);
      cyc(); invalidate = 1'b0; req(32'h200); @(negedge CLK);
      chk("inv_iREN", 32'(iREN), 32'h0);
      chk("inv_200_miss", 32'(ihit), 32'h0);
      wait_hit("refill_200", 10, n);
      cyc(); req(32'h600); @(negedge CLK);
      chk("abort_600_miss", 32'(ihit), 32'h0);
      wait_hit("fill_600", 10, n);
      cyc(); invalidate = 1'b1; @(negedge CLK);
      chk("inv_gates_hit", 32'(ihit), 32'h0);
      cyc(); invalidate = 1'b0; @(negedge CLK);
      chk("post_inv_miss", 32'(ihit), 32'h0);
      wait_hit("refill_600", 10, n);

      // Reset in the middle of a fill
      cyc(); req(32'h700); @(negedge CLK);
      cyc(); RST = 1'b1; @(negedge CLK);
      cyc(); RST = 1'b0; @(negedge CLK);
      chk("rstmid_iREN", 32'(iREN), 32'h0);
      chk("rstmid_700_miss", 32'(ihit), 32'h0);
      wait_hit("fill_700", 10, n);

`ifdef ICACHE_STATS_EN
      cyc(); imemREN = 1'b0; invalidate = 1'b1;
      cyc(); invalidate = 1'b0; @(negedge CLK);
      chk("stats_clr_hit", hit_count, 32'd0);
      chk("stats_clr_miss", miss_count, 32'd0);
      cyc(); req(32'h100); @(negedge CLK);
      wait_hit("stats_fill_100", 10, n);
      cyc(); req(32'h104);
      cyc(); req(32'h200); @(negedge CLK);
      wait_hit("stats_fill_200", 10, n);
      cyc(); req(32'h204);
      cyc(); req(32'h100);
      cyc(); imemREN = 1'b0; @(negedge CLK);
      chk("stats_hit_count", hit_count, 32'd5);
      chk("stats_miss_count", miss_count, 32'd2);
      cyc(); invalidate = 1'b1;
      cyc(); invalidate = 1'b0; @(negedge CLK);
      chk("stats_inv_hit", hit_count, 32'd0);
      chk("stats_inv_miss", miss_count, 32'd0);
`endif

      cyc(); imemREN = 1'b0;
      cyc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
